// File: rtl/mips_core_pkg.sv
// Shared core definitions: ALU opcode encoding and sizing defaults
// used by the reservation stations, ROB and CDB arbiter.
package mips_core_pkg;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOR = 5'd5,
    ALU_SLT = 5'd6,
    ALU_SLL = 5'd7,
    ALU_SRL = 5'd8,
    ALU_SRA = 5'd9
  } AluCtl;

  localparam int RS_DEPTH   = 8;
  localparam int RS_NUM_CDB = 2;
  localparam int ROB_TAG_W  = 4;

endpackage

// File: rtl/rs_oldest_ready_select.sv
// Priority encoder: lowest-index set bit of req wins.
// Ports: req in; grant one-hot out; idx of grant out; any out.
module rs_oldest_ready_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station_param.sv
// Age-ordered ALU reservation station (compacting queue, slot 0 oldest).
// Ports: dispatch (disp_*), NUM_CDB wakeup buses (cdb_*), issue (issue_*),
// flush, occupancy (count/full/empty); clk with sync active-high rst.
module reservation_station_param
  import mips_core_pkg::*;
#(
  parameter int DEPTH    = RS_DEPTH,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = ROB_TAG_W,
  parameter int NUM_CDB  = RS_NUM_CDB,
  parameter int ALUCTL_W = 5,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [ALUCTL_W-1:0]       disp_alu_ctl,
  input  logic [TAG_W-1:0]          disp_rob_tag,
  input  logic                      disp_j_rdy,
  input  logic                      disp_k_rdy,
  input  logic [DATA_W-1:0]         disp_j_val,
  input  logic [DATA_W-1:0]         disp_k_val,
  input  logic [TAG_W-1:0]          disp_j_tag,
  input  logic [TAG_W-1:0]          disp_k_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [ALUCTL_W-1:0]       issue_alu_ctl,
  output logic [DATA_W-1:0]         issue_op1,
  output logic [DATA_W-1:0]         issue_op2,
  output logic [TAG_W-1:0]          issue_rob_tag,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty
);

  typedef struct packed {
    logic              r;
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  t;
  } opnd_t;

  typedef struct packed {
    logic [ALUCTL_W-1:0] ctl;
    logic [TAG_W-1:0]    rob;
    opnd_t               j;
    opnd_t               k;
  } ent_t;

  // Counting down leaves the lowest matching channel as the winner.
  function automatic opnd_t wake(
    opnd_t                      o,
    logic [NUM_CDB-1:0]         cv,
    logic [NUM_CDB*TAG_W-1:0]   ct,
    logic [NUM_CDB*DATA_W-1:0]  cd
  );
    opnd_t res;
    res = o;
    if (!o.r) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cv[c] && ct[c*TAG_W +: TAG_W] == o.t) begin
          res.r = 1'b1;
          res.v = cd[c*DATA_W +: DATA_W];
        end
      end
    end
    return res;
  endfunction

  ent_t q  [DEPTH];
  ent_t w  [DEPTH];
  ent_t nq [DEPTH];
  ent_t ne;

  logic [DEPTH-1:0] rdyv;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic             any;
  logic             issue_fire;
  logic             disp_fire;
  logic [CNT_W-1:0] wr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i]     = q[i];
      w[i].j   = wake(q[i].j, cdb_valid, cdb_tag, cdb_value);
      w[i].k   = wake(q[i].k, cdb_valid, cdb_tag, cdb_value);
      rdyv[i]  = (CNT_W'(i) < count) && q[i].j.r && q[i].k.r;
    end
  end

  rs_oldest_ready_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .req   (rdyv),
    .grant (grant),
    .idx   (sel),
    .any   (any)
  );

  assign issue_valid = any;
  assign issue_fire  = any & issue_ready;
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign disp_ready  = !full | issue_fire;
  assign disp_fire   = disp_valid & disp_ready;
  assign wr          = count - CNT_W'(issue_fire);

  // grant is all-zero when nothing is ready, so outputs idle at 0.
  always_comb begin
    issue_alu_ctl = '0;
    issue_rob_tag = '0;
    issue_op1     = '0;
    issue_op2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_alu_ctl = q[i].ctl;
        issue_rob_tag = q[i].rob;
        issue_op1     = q[i].j.v;
        issue_op2     = q[i].k.v;
      end
    end
  end

  always_comb begin
    ne.ctl = disp_alu_ctl;
    ne.rob = disp_rob_tag;
    ne.j   = wake(opnd_t'({disp_j_rdy, disp_j_val, disp_j_tag}),
                  cdb_valid, cdb_tag, cdb_value);
    ne.k   = wake(opnd_t'({disp_k_rdy, disp_k_val, disp_k_tag}),
                  cdb_valid, cdb_tag, cdb_value);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nq[i] = w[i];
      if (issue_fire && IDX_W'(i) >= sel)
        nq[i] = w[(i < DEPTH - 1) ? i + 1 : i];
      if (disp_fire && CNT_W'(i) == wr)
        nq[i] = ne;
    end
  end

  // Payload needs no reset: validity is carried by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (flush)
      count <= '0;
    else
      count <= count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
  end

endmodule

// File: tb/tb_reservation_station_param.sv
// Self-checking bench: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_reservation_station_param;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int NC    = 2;
  localparam int CW    = 5;

  logic           clk = 1'b0;
  logic           rst, flush, disp_valid, disp_ready;
  logic [CW-1:0]  disp_alu_ctl;
  logic [TW-1:0]  disp_rob_tag;
  logic           disp_j_rdy, disp_k_rdy;
  logic [DW-1:0]  disp_j_val, disp_k_val;
  logic [TW-1:0]  disp_j_tag, disp_k_tag;
  logic [NC-1:0]  cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_value;
  logic           issue_valid, issue_ready;
  logic [CW-1:0]  issue_alu_ctl;
  logic [DW-1:0]  issue_op1, issue_op2;
  logic [TW-1:0]  issue_rob_tag;
  logic [3:0]     count;
  logic           full, empty;

  always #5 clk = ~clk;

  reservation_station_param dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_alu_ctl(disp_alu_ctl), .disp_rob_tag(disp_rob_tag),
    .disp_j_rdy(disp_j_rdy), .disp_k_rdy(disp_k_rdy),
    .disp_j_val(disp_j_val), .disp_k_val(disp_k_val),
    .disp_j_tag(disp_j_tag), .disp_k_tag(disp_k_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_ctl(issue_alu_ctl), .issue_op1(issue_op1),
    .issue_op2(issue_op2), .issue_rob_tag(issue_rob_tag),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    bit [4:0]  ctl;
    bit [3:0]  rob;
    bit        jr;
    bit [31:0] jv;
    bit [3:0]  jt;
    bit        kr;
    bit [31:0] kv;
    bit [3:0]  kt;
  } m_t;

  m_t mq[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void wake(inout bit r, inout bit [31:0] v,
                               input bit [3:0] t);
    if (r) return;
    for (int c = 0; c < NC; c++) begin
      if (cdb_valid[c] && cdb_tag[c*TW +: TW] == t) begin
        r = 1'b1;
        v = cdb_value[c*DW +: DW];
        return;
      end
    end
  endfunction

  task automatic cycle();
    int s;
    bit fire, dfire;
    m_t e;
    #1;
    s = -1;
    foreach (mq[i]) if (s < 0 && mq[i].jr && mq[i].kr) s = i;
    fire  = (s >= 0) && issue_ready;
    dfire = disp_valid && (mq.size() < DEPTH || fire);
    if (!rst) begin
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("disp_ready", disp_ready, (mq.size() < DEPTH) || fire);
      chk("issue_valid", issue_valid, s >= 0);
      if (s >= 0) begin
        chk("issue_ctl", issue_alu_ctl, mq[s].ctl);
        chk("issue_rob", issue_rob_tag, mq[s].rob);
        chk("issue_op1", issue_op1, mq[s].jv);
        chk("issue_op2", issue_op2, mq[s].kv);
      end else begin
        chk("idle_ops", {issue_op1, issue_op2}, 64'd0);
        chk("idle_ctl", {issue_alu_ctl, issue_rob_tag}, 64'd0);
      end
    end
    if (rst || flush) mq.delete();
    else begin
      foreach (mq[i]) begin
        e = mq[i];
        wake(e.jr, e.jv, e.jt);
        wake(e.kr, e.kv, e.kt);
        mq[i] = e;
      end
      if (fire) mq.delete(s);
      if (dfire) begin
        e.ctl = disp_alu_ctl; e.rob = disp_rob_tag;
        e.jr = disp_j_rdy; e.jv = disp_j_val; e.jt = disp_j_tag;
        e.kr = disp_k_rdy; e.kv = disp_k_val; e.kt = disp_k_tag;
        wake(e.jr, e.jv, e.jt);
        wake(e.kr, e.kv, e.kt);
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; issue_ready = 0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    disp_alu_ctl = '0; disp_rob_tag = '0;
    disp_j_rdy = 0; disp_j_val = '0; disp_j_tag = '0;
    disp_k_rdy = 0; disp_k_val = '0; disp_k_tag = '0;
  endtask

  task automatic disp(bit [3:0] rob, bit jr, bit [31:0] jv, bit [3:0] jt,
                      bit kr, bit [31:0] kv, bit [3:0] kt);
    disp_valid = 1; disp_alu_ctl = 5'(rob) ^ 5'd3; disp_rob_tag = rob;
    disp_j_rdy = jr; disp_j_val = jv; disp_j_tag = jt;
    disp_k_rdy = kr; disp_k_val = kv; disp_k_tag = kt;
  endtask

  task automatic cdb(int c, bit [3:0] t, bit [31:0] v);
    cdb_valid[c] = 1'b1;
    cdb_tag[c*TW +: TW] = t;
    cdb_value[c*DW +: DW] = v;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    cycle();
    idle();
    cycle();

    // basic ready dispatch then issue
    disp(4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    disp_alu_ctl = 5'd0;
    cycle();
    idle();
    chk("t1_valid", issue_valid, 1);
    chk("t1_op1", issue_op1, 5);
    chk("t1_op2", issue_op2, 7);
    chk("t1_rob", issue_rob_tag, 3);
    issue_ready = 1;
    cycle();
    chk("t1_empty", empty, 1);

    // younger ready entry bypasses older waiting one; tag 0 wakeup
    idle();
    disp(4'd1, 0, 32'd0, 4'd0, 1, 32'd2, 4'd0);
    cycle();
    disp(4'd2, 1, 32'd10, 4'd0, 1, 32'd20, 4'd0);
    cycle();
    idle(); issue_ready = 1;
    chk("t2_first", issue_rob_tag, 2);
    cycle();
    chk("t2_wait", issue_valid, 0);
    cdb(1, 4'd0, 32'hAB);
    cycle();
    idle(); issue_ready = 1;
    chk("t2_rob", issue_rob_tag, 1);
    chk("t2_op1", issue_op1, 32'hAB);
    cycle();

    // fill, then simultaneous issue+dispatch when full
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'(i), 1, 32'(i + 100), 4'd0, 1, 32'(i), 4'd0);
      cycle();
    end
    idle();
    chk("t3_full", full, 1);
    chk("t3_dr", disp_ready, 0);
    issue_ready = 1;
    disp(4'd15, 1, 32'h55, 4'd0, 1, 32'h66, 4'd0);
    cycle();
    chk("t3_cnt", count, 8);
    idle(); issue_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t3_last", issue_rob_tag, 15);
      cycle();
    end

    // dispatch bypass from CDB
    idle();
    disp(4'd4, 0, 32'd0, 4'd9, 1, 32'd1, 4'd0);
    cdb(0, 4'd9, 32'h1234);
    cycle();
    idle();
    chk("t4_valid", issue_valid, 1);
    chk("t4_op1", issue_op1, 32'h1234);
    issue_ready = 1;
    cycle();

    // dual-channel wakeup, age-order issue
    idle();
    disp(4'd5, 0, 32'd0, 4'd4, 1, 32'd1, 4'd0);
    cycle();
    disp(4'd6, 0, 32'd0, 4'd6, 1, 32'd1, 4'd0);
    cycle();
    idle();
    cdb(0, 4'd4, 32'h11);
    cdb(1, 4'd6, 32'h22);
    cycle();
    idle(); issue_ready = 1;
    chk("t5_rob_a", issue_rob_tag, 5);
    chk("t5_op_a", issue_op1, 32'h11);
    cycle();
    chk("t5_rob_b", issue_rob_tag, 6);
    chk("t5_op_b", issue_op1, 32'h22);
    cycle();

    // flush with dispatch, then rst mid-fill
    idle();
    for (int i = 0; i < 5; i++) begin
      disp(4'(i), 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
      cycle();
    end
    flush = 1;
    cycle();
    idle();
    chk("t6_cnt", count, 0);
    chk("t6_iv", issue_valid, 0);
    for (int i = 0; i < 3; i++) begin
      disp(4'(i), 1, 32'd1, 4'd0, 1, 32'd2, 4'd0);
      cycle();
    end
    rst = 1;
    cycle();
    idle();
    chk("t7_cnt", count, 0);
    chk("t7_empty", empty, 1);
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 59) == 0);
      issue_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0)
        disp(4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)));
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 2) == 0)
          cdb(c, 4'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
- Parametrised, age-ordered ALU reservation station; successor to the fixed-size single-CDB station.
- Sits between decode/rename (dispatch side) and the ALU (issue side), and snoops NUM_CDB common data buses for operand wakeup.
- Adds explicit operand-ready bits (tag value 0 is a legal ROB tag), oldest-ready-first issue with valid/ready handshakes, multi-CDB wakeup, same-cycle dispatch bypass, and flush.

Parameters:
- DEPTH, 8, number of entries (>=2)
- DATA_W, 32, operand width
- TAG_W, 4, ROB tag width
- NUM_CDB, 2, number of CDB broadcast channels
- ALUCTL_W, 5, width of the mips_core_pkg::AluCtl encoding

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash every entry (mispredict recovery)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept this cycle
- disp_alu_ctl  in  ALUCTL_W  ALU opcode
- disp_rob_tag  in  TAG_W  destination ROB tag
- disp_j_rdy / disp_k_rdy  in  1 each  operand value already available
- disp_j_val / disp_k_val  in  DATA_W each  operand value (valid when rdy=1)
- disp_j_tag / disp_k_tag  in  TAG_W each  producer tag (used when rdy=0)
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W  channel c in bits [c*TAG_W +: TAG_W]
- cdb_value  in  NUM_CDB*DATA_W  channel c in bits [c*DATA_W +: DATA_W]
- issue_valid  out  1  an entry with both operands ready is presented
- issue_ready  in  1  ALU accepts
- issue_alu_ctl  out  ALUCTL_W  opcode of the presented entry
- issue_op1 / issue_op2  out  DATA_W each  operand values
- issue_rob_tag  out  TAG_W  ROB tag of the presented entry
- count  out  $clog2(DEPTH+1)  occupied entries
- full / empty  out  1 each  count==DEPTH / count==0

Behaviour:
- Storage is a compacting queue. Slot 0 is the oldest entry; slots [0, count-1] are valid. Each entry holds alu_ctl, rob_tag, and per operand {rdy, val, tag}.
- Reset (rst=1 at an edge): all valid bits cleared, count=0, empty=1, full=0, issue_valid=0. Issue data outputs are driven to 0 whenever issue_valid=0.
- Issue select is combinational from registered state only. The presented entry is the lowest-index valid entry with j.rdy & k.rdy. issue_valid=1 iff such an entry exists.
- Issue fire = issue_valid & issue_ready. On fire, the selected entry is removed at the edge and every entry above it shifts down one slot.
- disp_ready = !full | issue_fire. It depends on the combinational issue_ready, so there is no path from disp_* to issue_*.
- Dispatch fire = disp_valid & disp_ready. The new entry is written to slot count - issue_fire.
- Wakeup at each edge: for every valid entry and operand with rdy=0, if any channel has cdb_valid=1 and a tag match, set rdy=1 and latch cdb_value. If multiple channels match, the lowest channel index wins.
- Shifting entries carry their wakeup updates from the same cycle.
- Dispatch bypass: if a dispatched operand has rdy=0 and its tag matches a valid CDB channel in the same cycle, it is stored with rdy=1 and that channel's value.
- Latency:
  - Operand-ready dispatch at edge N gives issue_valid at N+1.
  - Wakeup at edge N makes the entry eligible after N; it issues at the earliest from N+1.
- Simultaneous issue fire and dispatch fire: count is unchanged. This works when full; the new entry lands at slot DEPTH-1.
- Flush: at the edge, all entries are invalidated and count=0. Any same-cycle dispatch is dropped and any same-cycle issue fire is ignored by the station. rst has priority over flush.
- count is updated as count + dispatch_fire - issue_fire and never wraps. Dispatch attempted with disp_ready=0 has no effect.

Decomposition:
- Add to mips_core_pkg: the AluCtl typedef (existing) and the RS_DEPTH, RS_NUM_CDB, ROB_TAG_W defaults as localparams shared with the ROB and CDB arbiter.
- The entry struct is declared locally, since it depends on the parameters.
- One sub-module, rs_oldest_ready_select: DEPTH-wide ready vector in, one-hot grant plus index out (priority encoder). It is reused by the load/store station.

Test Plan:
- Reset, then dispatch {ctl=ADD, rob=3, j=5 rdy, k=7 rdy} -> next cycle issue_valid=1, op1=5, op2=7, rob_tag=3; with issue_ready=1, count returns 0 and empty=1.
- Dispatch rob=1 with j waiting on tag 0 (k ready), then rob=2 fully ready -> rob=2 issues first. Then CDB ch1 {tag 0, value 0xAB} -> next cycle rob=1 issues with op1=0xAB (tag 0 is legal).
- Fill 8 entries with issue_ready=0 -> full=1, disp_ready=0. Then issue_ready=1 plus dispatch the same cycle -> disp_ready=1, count stays 8, new entry sits at slot 7.
- Dispatch an operand waiting on tag 9 while CDB ch0 broadcasts {tag 9, 0x1234} the same cycle -> entry captured ready, issues next cycle with 0x1234.
- Two entries waiting on tags 4 and 6; ch0={4,0x11} and ch1={6,0x22} in the same cycle -> both wake, and issue in age order on consecutive cycles.
- With 5 entries valid, assert flush together with disp_valid -> count=0, empty=1, issue_valid=0 next cycle, dispatched entry absent. Assert rst mid-fill -> same result.
